pong_engine: RTL
================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines.
- PAD_W, 8: paddle width in pixels.
- PAD_H, 64: paddle height in pixels.
- BALL, 8: ball side in pixels.
- PAD_SPD, 4: paddle step per frame.
- BALL_SPD, 2: ball step per axis per frame.
- SCORE_MAX, 9: winning score.
- SERVE_FR, 60: serve hold, in frames.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active high.
- pix_en, in, 1: one pixel slot this cycle.
- px, in, 10: current pixel column from the VGA timing stage.
- py, in, 10: current pixel line from the VGA timing stage.
- vid_active, in, 1: px,py inside the active area.
- frame_tick, in, 1: one-cycle pulse, once per frame, inside vertical blanking.
- p1_up, p1_dn, p2_up, p2_dn, in, 1 each: paddle buttons, already synchronised.
- rgb, out, 3: pixel colour, registered.
- score_l, score_r, out, 4 each: player scores.

Function
REQ-004 rgb SHALL update only on cycles with pix_en=1, with one-cycle latency from the px/py sample, and SHALL hold its value otherwise.
REQ-005 rgb SHALL be 3'b000 when vid_active=0; otherwise 3'b111 when the pixel lies in the ball or in either paddle, else 3'b000.
REQ-006 Paddle x-ranges SHALL be fixed: left paddle [16, 16+PAD_W), right paddle [H_RES-16-PAD_W, H_RES-16).
REQ-007 Paddle y and ball bx/by SHALL denote top-left corners, 10-bit unsigned; all range compares SHALL use 11-bit sums so that no overflow occurs.
REQ-008 All game state SHALL change only on cycles with frame_tick=1.
REQ-009 On the same cycle as frame_tick, rendering SHALL use the pre-update register values.
REQ-010 Paddle move per tick:
- up only: y-=PAD_SPD, clamped at 0.
- down only: y+=PAD_SPD, clamped at V_RES-PAD_H.
- both or neither pressed: no move.
- Paddles SHALL move in every game state except GAMEOVER.
REQ-011 The FSM SHALL have the states SERVE, PLAY, POINT and GAMEOVER.
REQ-012 SERVE:
- The ball SHALL be held at (H_RES/2-BALL/2, V_RES/2-BALL/2).
- serve_cnt SHALL increment per tick.
- On the tick where serve_cnt reaches SERVE_FR-1, serve_cnt SHALL clear and the state SHALL go to PLAY.
REQ-013 PLAY: each tick, bx and by SHALL each step BALL_SPD in the direction of dx and dy.
REQ-014 Wall bounce: if the next by is <0, by SHALL be set to 0 and dy forced down; if the next by is >V_RES-BALL, by SHALL be set to V_RES-BALL and dy forced up.
REQ-015 Paddle hit:
- Condition: ball moving left, next bx <= 16+PAD_W, current bx >= 16+PAD_W, and vertical overlap by<py_l+PAD_H and by+BALL>py_l.
- Action: bx SHALL be set to 16+PAD_W and dx forced right.
- The right paddle SHALL behave mirror-symmetrically.
REQ-016 Miss: if the next bx is <=0, the right player scores; if the next bx is >=H_RES-BALL, the left player scores; in either case the state SHALL go to POINT.
REQ-017 If a wall bounce and a paddle hit occur on the same tick, both SHALL apply.
REQ-018 A paddle hit SHALL take priority over a miss on the same tick.
REQ-019 POINT (one tick):
- The scorer's score SHALL increment.
- If the new score equals SCORE_MAX, the state SHALL go to GAMEOVER.
- Otherwise the ball SHALL be centred, dx set toward the player who lost the point, dy kept, and the state SHALL go to SERVE.
REQ-020 GAMEOVER: the ball and scores SHALL be frozen; on a tick with any button high, both scores SHALL clear, the ball SHALL be centred, and the state SHALL go to SERVE.
REQ-021 Scores SHALL never exceed SCORE_MAX and SHALL never wrap.

Reset
REQ-022 On rst=1 at a clk edge, the following SHALL be set:
- state=SERVE, serve_cnt=0.
- score_l=score_r=0.
- Both paddle y=(V_RES-PAD_H)/2 = 208.
- Ball=(316,236), dx=right, dy=down.
- rgb=3'b000.
REQ-023 rst SHALL override frame_tick and pix_en on the same cycle, including mid-PLAY and in GAMEOVER.

Verification
REQ-024 Reset, then 60 frame_ticks -> the state enters PLAY on tick 60; the ball stays at (316,236) until tick 61, then moves to (318,238).
REQ-025 Left paddle at y=0 with p1_up held for 3 ticks -> y stays at 0; with p1_dn held 60 ticks -> y saturates at 416.
REQ-026 Ball at by=1, moving up, in PLAY -> by=0 and dy=down after the tick.
REQ-027 Ball moving left at bx=25, left paddle y=200, by=230 -> bx=24 and dx=right; the same case with paddle y=0 -> the ball continues left, then on reaching bx<=0 score_r increments and the state enters SERVE with dx=left.
REQ-028 score_l=8 and a left point -> score_l=9, GAMEOVER, ball frozen; then p2_up on a tick -> scores 0, state SERVE.
REQ-029 Raster with pix_en every 4th cycle -> rgb=3'b111 exactly at ball and paddle pixels, one pix_en slot late; rgb=3'b000 whenever vid_active=0.

Source files
------------

// File: rtl/pong_engine.sv
// Pong game engine: paddle/ball state advanced once per frame_tick, plus a
// registered one-bit-per-pixel renderer sampled on pix_en slots.
module pong_engine #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 64,
    parameter int BALL      = 8,
    parameter int PAD_SPD   = 4,
    parameter int BALL_SPD  = 2,
    parameter int SCORE_MAX = 9,
    parameter int SERVE_FR  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       vid_active,
    input  logic       frame_tick,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [2:0] rgb,
    output logic [3:0] score_l,
    output logic [3:0] score_r
);

    typedef enum logic [1:0] {
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_GAMEOVER
    } state_t;

    localparam int SC_W = (SERVE_FR > 1) ? $clog2(SERVE_FR) : 1;

    localparam logic [SC_W-1:0]   SC_LAST      = SC_W'(SERVE_FR - 1);
    localparam logic [9:0]        PAD_Y0       = 10'((V_RES - PAD_H) / 2);
    localparam logic [9:0]        PAD_Y_MAX    = 10'(V_RES - PAD_H);
    localparam logic [9:0]        PAD_STEP     = 10'(PAD_SPD);
    localparam logic [9:0]        BALL_X0      = 10'(H_RES / 2 - BALL / 2);
    localparam logic [9:0]        BALL_Y0      = 10'(V_RES / 2 - BALL / 2);
    localparam logic [9:0]        BALL_X_MAX   = 10'(H_RES - BALL);
    localparam logic [9:0]        BALL_Y_MAX   = 10'(V_RES - BALL);
    localparam logic [9:0]        BALL_X_HIT_L = 10'(16 + PAD_W);
    localparam logic [9:0]        BALL_X_HIT_R = 10'(H_RES - 16 - PAD_W - BALL);
    localparam logic [10:0]       PAD_L_X0     = 11'd16;
    localparam logic [10:0]       PAD_L_X1     = 11'(16 + PAD_W);
    localparam logic [10:0]       PAD_R_X0     = 11'(H_RES - 16 - PAD_W);
    localparam logic [10:0]       PAD_R_X1     = 11'(H_RES - 16);
    localparam logic [10:0]       PAD_H11      = 11'(PAD_H);
    localparam logic [10:0]       BALL11       = 11'(BALL);
    localparam logic signed [11:0] S_SPD       = 12'(BALL_SPD);
    localparam logic signed [11:0] S_BALL      = 12'(BALL);
    localparam logic signed [11:0] S_X_MAX     = 12'(H_RES - BALL);
    localparam logic signed [11:0] S_Y_MAX     = 12'(V_RES - BALL);
    localparam logic signed [11:0] S_HIT_L     = 12'(16 + PAD_W);
    localparam logic signed [11:0] S_HIT_R     = 12'(H_RES - 16 - PAD_W);
    localparam logic [3:0]        SC_MAX       = 4'(SCORE_MAX);

    state_t          state_q, state_d;
    logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [3:0]      score_l_q, score_l_d;
    logic [3:0]      score_r_q, score_r_d;
    logic [9:0]      pad_l_q, pad_l_d;
    logic [9:0]      pad_r_q, pad_r_d;
    logic [9:0]      bx_q, bx_d;
    logic [9:0]      by_q, by_d;
    logic            dx_q, dx_d;        // 1 = moving right
    logic            dy_q, dy_d;        // 1 = moving down
    logic            scorer_l_q, scorer_l_d;
    logic [2:0]      rgb_q, rgb_d;

    logic signed [11:0] nbx, nby;
    logic               ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
    logic [3:0]         sc_cur, sc_new;
    logic [10:0]        x11, y11;
    logic               in_ball, in_pl, in_pr;

    function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
        logic [10:0] yw;
        yw       = {1'b0, y} + {1'b0, PAD_STEP};
        pad_step = y;
        if (up && !dn) begin
            pad_step = (y < PAD_STEP) ? 10'd0 : y - PAD_STEP;
        end else if (dn && !up) begin
            pad_step = (yw > {1'b0, PAD_Y_MAX}) ? PAD_Y_MAX : yw[9:0];
        end
    endfunction

    // Collision terms use the pre-tick ball and paddle positions.
    always_comb begin
        nbx    = $signed({2'b00, bx_q}) + (dx_q ? S_SPD : -S_SPD);
        nby    = $signed({2'b00, by_q}) + (dy_q ? S_SPD : -S_SPD);
        ov_l   = ({1'b0, by_q} < {1'b0, pad_l_q} + PAD_H11) &&
                 ({1'b0, by_q} + BALL11 > {1'b0, pad_l_q});
        ov_r   = ({1'b0, by_q} < {1'b0, pad_r_q} + PAD_H11) &&
                 ({1'b0, by_q} + BALL11 > {1'b0, pad_r_q});
        hit_l  = !dx_q && (nbx <= S_HIT_L) && ({1'b0, bx_q} >= PAD_L_X1) && ov_l;
        hit_r  = dx_q && (nbx + S_BALL >= S_HIT_R) && ({1'b0, bx_q} + BALL11 <= PAD_R_X0) && ov_r;
        miss_l = (nbx <= 12'sd0);
        miss_r = (nbx >= S_X_MAX);
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        pad_l_d     = pad_l_q;
        pad_r_d     = pad_r_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        scorer_l_d  = scorer_l_q;
        sc_cur      = scorer_l_q ? score_l_q : score_r_q;
        sc_new      = (sc_cur < SC_MAX) ? sc_cur + 4'd1 : sc_cur;

        if (frame_tick) begin
            if (state_q != S_GAMEOVER) begin
                pad_l_d = pad_step(pad_l_q, p1_up, p1_dn);
                pad_r_d = pad_step(pad_r_q, p2_up, p2_dn);
            end
            case (state_q)
                S_SERVE: begin
                    bx_d = BALL_X0;
                    by_d = BALL_Y0;
                    if (serve_cnt_q == SC_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = S_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SC_W'(1);
                    end
                end
                S_PLAY: begin
                    if (nby < 12'sd0) begin
                        by_d = '0;
                        dy_d = 1'b1;
                    end else if (nby > S_Y_MAX) begin
                        by_d = BALL_Y_MAX;
                        dy_d = 1'b0;
                    end else begin
                        by_d = nby[9:0];
                    end
                    // a paddle return beats a miss on the same tick
                    if (hit_l) begin
                        bx_d = BALL_X_HIT_L;
                        dx_d = 1'b1;
                    end else if (hit_r) begin
                        bx_d = BALL_X_HIT_R;
                        dx_d = 1'b0;
                    end else if (miss_l) begin
                        bx_d       = '0;
                        scorer_l_d = 1'b0;
                        state_d    = S_POINT;
                    end else if (miss_r) begin
                        bx_d       = BALL_X_MAX;
                        scorer_l_d = 1'b1;
                        state_d    = S_POINT;
                    end else begin
                        bx_d = nbx[9:0];
                    end
                end
                S_POINT: begin
                    if (scorer_l_q) begin
                        score_l_d = sc_new;
                    end else begin
                        score_r_d = sc_new;
                    end
                    if (sc_new == SC_MAX) begin
                        state_d = S_GAMEOVER;
                    end else begin
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                        dx_d    = scorer_l_q;   // serve toward the player who lost
                        state_d = S_SERVE;
                    end
                end
                S_GAMEOVER: begin
                    if (p1_up || p1_dn || p2_up || p2_dn) begin
                        score_l_d = '0;
                        score_r_d = '0;
                        bx_d      = BALL_X0;
                        by_d      = BALL_Y0;
                        state_d   = S_SERVE;
                    end
                end
                default: state_d = S_SERVE;
            endcase
        end
    end

    always_comb begin
        x11     = {1'b0, px};
        y11     = {1'b0, py};
        in_ball = (x11 >= {1'b0, bx_q}) && (x11 < {1'b0, bx_q} + BALL11) &&
                  (y11 >= {1'b0, by_q}) && (y11 < {1'b0, by_q} + BALL11);
        in_pl   = (x11 >= PAD_L_X0) && (x11 < PAD_L_X1) &&
                  (y11 >= {1'b0, pad_l_q}) && (y11 < {1'b0, pad_l_q} + PAD_H11);
        in_pr   = (x11 >= PAD_R_X0) && (x11 < PAD_R_X1) &&
                  (y11 >= {1'b0, pad_r_q}) && (y11 < {1'b0, pad_r_q} + PAD_H11);
        rgb_d   = rgb_q;
        if (pix_en) begin
            rgb_d = (vid_active && (in_ball || in_pl || in_pr)) ? 3'b111 : 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SERVE;
            serve_cnt_q <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            pad_l_q     <= PAD_Y0;
            pad_r_q     <= PAD_Y0;
            bx_q        <= BALL_X0;
            by_q        <= BALL_Y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            scorer_l_q  <= 1'b0;
            rgb_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            pad_l_q     <= pad_l_d;
            pad_r_q     <= pad_r_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            scorer_l_q  <= scorer_l_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb     = rgb_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule
